vrf_bank_xbar: RTL
==================

# vrf_bank_xbar

Parametrised vector-register-file crossbar: NUM_LANES execution lanes issue read/write requests to NUM_BANKS vector register banks, each bank with one read port and one write port per cycle. It generalises the fixed vector-register/crossbar pairing: bank and lane counts are parameters, per-bank round-robin arbitration is added, and lanes use a valid/ready handshake with a registered read response. It sits between the execute-stage lanes and the vector register storage, which it contains.

## Interface
- NUM_LANES, 4, number of requesting lanes (≥1)
- NUM_BANKS, 8, number of vector register banks (≥1; need not be a power of two)
- BANK_DEPTH, 64, entries per bank
- DATA_WIDTH, 64, bits per entry
- Derived, not overridable: BANK_W = max(1,$clog2(NUM_BANKS)), ADDR_W = max(1,$clog2(BANK_DEPTH))

- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- req_vld  in  [NUM_LANES]  lane request valid
- req_we  in  [NUM_LANES]  1 = write, 0 = read
- req_bank  in  [NUM_LANES][BANK_W]  target bank
- req_addr  in  [NUM_LANES][ADDR_W]  entry within bank
- req_wdata  in  [NUM_LANES][DATA_WIDTH]  write data
- req_rdy  out  [NUM_LANES]  request accepted this cycle (combinational)
- rsp_vld  out  [NUM_LANES]  read response valid
- rsp_err  out  [NUM_LANES]  response for out-of-range bank/addr
- rsp_data  out  [NUM_LANES][DATA_WIDTH]  read data

## Operation
- Transfer occurs when req_vld & req_rdy; lane holds all req_* stable while req_vld=1 and req_rdy=0.
- Per bank, two independent round-robin arbiters: read port among lanes with req_we=0 targeting that bank; write port among lanes with req_we=1. Each grants at most one lane per cycle.
- RR pointer per arbiter: search starts at pointer; on a grant, pointer ← granted lane + 1 (mod NUM_LANES); no grant → pointer unchanged. Reset value 0.
- Read and write to the same bank in one cycle are both granted. Same addr: read returns OLD contents (read-before-write).
- Writes commit to storage at the granting edge; visible to reads granted in the following cycle or later.
- Out-of-range request (req_bank ≥ NUM_BANKS or req_addr ≥ BANK_DEPTH): req_rdy=1 immediately, no arbitration, no storage effect; reads return rsp_vld=1, rsp_err=1, rsp_data=0; writes are silently dropped.
- Storage contents not reset; only control state and outputs reset.

## Timing
- req_rdy combinational from req_* and arbiter pointers, same cycle; forced 0 while reset=1.
- Read latency 1: read accepted at edge N → rsp_vld=1 with rsp_data during cycle N+1, for exactly one cycle. No backpressure on responses.
- Back-to-back reads from one lane sustained at 1/cycle when uncontended.
- Write latency: storage updated at accepting edge.
- Reset values: rsp_vld=0, rsp_err=0, rsp_data=0, all pointers 0, req_rdy=0.
- Reset mid-operation: a read accepted in the cycle before reset asserts produces no response; pending unaccepted requests are ignored until reset deasserts.
- Worst-case wait for a persistently requesting lane: NUM_LANES−1 cycles (RR fairness).

## Structure
- Shared package: DATA_WIDTH/NUM_BANKS/BANK_DEPTH defaults (the existing vector register width, count and depth constants), and a lane request struct type.
- One sub-module: rr_arbiter (parameter N; inputs req[N], advance; output one-hot grant; owns pointer). Instantiated 2×NUM_BANKS.
- Storage: one DATA_WIDTH×BANK_DEPTH array per bank, generate loop.

## Test plan
- Single lane: write bank 2 addr 5 = 0xDEAD_BEEF, next cycle read → req_rdy=1 both cycles, rsp_vld at read+1 with 0xDEAD_BEEF, rsp_err=0.
- 4 lanes all read bank 0 continuously from reset → grants lane 0,1,2,3,0… one per cycle; each lane waits ≤3 cycles.
- Same cycle: lane 0 writes bank 1 addr 3 = 0x11, lane 1 reads bank 1 addr 3 (previously 0x22) → both rdy=1; lane 1 gets 0x22; read next cycle gets 0x11.
- 4 lanes to 4 distinct banks, mixed read/write → all req_rdy=1 in same cycle, no stalls.
- NUM_BANKS=6, read bank 7 → req_rdy=1, next cycle rsp_vld=1, rsp_err=1, rsp_data=0; write bank 6 → accepted, no bank changed.
- Read accepted, reset asserted next cycle → rsp_vld=0 throughout reset; pointers 0 afterwards (lane 0 wins first contention).

Source files
------------

// File: rtl/vrf_bank_xbar_pkg.sv
// Shared constants and types for the vector register file bank crossbar.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package vrf_bank_xbar_pkg;

   // Default vector register geometry: entry width, bank count, entries per bank
   localparam int VRF_DATA_WIDTH = 64;
   localparam int VRF_NUM_BANKS  = 8;
   localparam int VRF_BANK_DEPTH = 64;

   // Index width for a count, never narrower than one bit
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   // One lane's request at the default geometry
   typedef struct packed {
      logic                                   vld;
      logic                                   we;
      logic [clog2_min1(VRF_NUM_BANKS)-1:0]   bank;
      logic [clog2_min1(VRF_BANK_DEPTH)-1:0]  addr;
      logic [VRF_DATA_WIDTH-1:0]              wdata;
   } vrf_lane_req_t;

endpackage

// File: rtl/vrf_bank_xbar_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: grant is combinational; pointer moves at the edge after a taken grant.
// Backpressure: none; the caller signals via i_advance that the grant was consumed.
module rr_arbiter
   import vrf_bank_xbar_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic [N-1:0] i_req,
   input  logic         i_advance,
   output logic [N-1:0] o_grant
);
   localparam int PTR_W = clog2_min1(N);

   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_ptr_nxt;

   // Lane index at a given offset from base, wrapping at N (inputs stay below 2N)
   function automatic int wrap_idx(input int base, input int off);
      int s;
      s = base + off;
      return (s >= N) ? s - N : s;
   endfunction

   // Scan from farthest to nearest offset so the requester closest to the pointer wins
   always_comb begin
      o_grant   = '0;
      w_ptr_nxt = r_ptr;
      for (int off = N - 1; off >= 0; off--) begin
         for (int i = 0; i < N; i++) begin
            if (i == wrap_idx(int'(r_ptr), off) && i_req[i]) begin
               o_grant    = '0;
               o_grant[i] = 1'b1;
               w_ptr_nxt  = PTR_W'(wrap_idx(i, 1));
            end
         end
      end
   end

   // Pointer moves past the winner only when a grant was actually taken
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ptr <= '0;
      end else if (i_advance && (|o_grant)) begin
         r_ptr <= w_ptr_nxt;
      end
   end

endmodule

// File: rtl/vrf_bank_xbar.sv
// Lane-to-bank crossbar over banked vector register storage, RR arbitration per bank port.
// Latency: writes commit at the accepting edge; read data is registered, valid 1 cycle later.
// Backpressure: req_rdy is the per-cycle grant; responses cannot be stalled.
module vrf_bank_xbar
   import vrf_bank_xbar_pkg::*;
#(
   parameter  int NUM_LANES  = 4,
   parameter  int NUM_BANKS  = VRF_NUM_BANKS,
   parameter  int BANK_DEPTH = VRF_BANK_DEPTH,
   parameter  int DATA_WIDTH = VRF_DATA_WIDTH,
   localparam int BANK_W     = clog2_min1(NUM_BANKS),
   localparam int ADDR_W     = clog2_min1(BANK_DEPTH)
) (
   input  logic                                 i_clk,
   input  logic                                 i_reset,
   input  logic [NUM_LANES-1:0]                 i_req_vld,
   input  logic [NUM_LANES-1:0]                 i_req_we,
   input  logic [NUM_LANES-1:0][BANK_W-1:0]     i_req_bank,
   input  logic [NUM_LANES-1:0][ADDR_W-1:0]     i_req_addr,
   input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] i_req_wdata,
   output logic [NUM_LANES-1:0]                 o_req_rdy,
   output logic [NUM_LANES-1:0]                 o_rsp_vld,
   output logic [NUM_LANES-1:0]                 o_rsp_err,
   output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] o_rsp_data
);
   typedef struct packed {
      logic                  vld;
      logic                  we;
      logic [BANK_W-1:0]     bank;
      logic [ADDR_W-1:0]     addr;
      logic [DATA_WIDTH-1:0] wdata;
   } lane_req_t;

   lane_req_t                           w_lane [NUM_LANES];
   logic [NUM_LANES-1:0]                w_oor;
   logic [NUM_LANES-1:0]                w_rd_req [NUM_BANKS];
   logic [NUM_LANES-1:0]                w_wr_req [NUM_BANKS];
   logic [NUM_LANES-1:0]                w_rd_gnt [NUM_BANKS];
   logic [NUM_LANES-1:0]                w_wr_gnt [NUM_BANKS];
   logic [DATA_WIDTH-1:0]               w_rd_data [NUM_BANKS];
   logic [NUM_LANES-1:0]                w_gnt_any;
   logic [NUM_LANES-1:0]                w_rd_acc;
   logic [NUM_LANES-1:0][DATA_WIDTH-1:0] w_lane_rdata;

   logic [NUM_LANES-1:0]                 r_rsp_vld;
   logic [NUM_LANES-1:0]                 r_rsp_err;
   logic [NUM_LANES-1:0][DATA_WIDTH-1:0] r_rsp_data;

   // Decode each lane into range check and per-bank read/write request vectors
   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         w_lane[l] = '{vld: i_req_vld[l], we: i_req_we[l], bank: i_req_bank[l],
                       addr: i_req_addr[l], wdata: i_req_wdata[l]};
         // Out-of-range requests bypass arbitration entirely
         w_oor[l]  = (32'(i_req_bank[l]) >= 32'(NUM_BANKS)) ||
                     (32'(i_req_addr[l]) >= 32'(BANK_DEPTH));
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
         w_rd_req[b] = '0;
         w_wr_req[b] = '0;
         for (int l = 0; l < NUM_LANES; l++) begin
            if (w_lane[l].vld && !w_oor[l] && (32'(w_lane[l].bank) == b)) begin
               w_rd_req[b][l] = !w_lane[l].we;
               w_wr_req[b][l] = w_lane[l].we;
            end
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] r_mem [BANK_DEPTH];
      logic [ADDR_W-1:0]     w_rd_addr;
      logic [ADDR_W-1:0]     w_wr_addr;
      logic [DATA_WIDTH-1:0] w_wr_data;

      rr_arbiter #(.N(NUM_LANES)) u_rd_arb (
         .i_clk     (i_clk),
         .i_reset   (i_reset),
         .i_req     (w_rd_req[b]),
         .i_advance (|w_rd_gnt[b]),
         .o_grant   (w_rd_gnt[b])
      );

      rr_arbiter #(.N(NUM_LANES)) u_wr_arb (
         .i_clk     (i_clk),
         .i_reset   (i_reset),
         .i_req     (w_wr_req[b]),
         .i_advance (|w_wr_gnt[b]),
         .o_grant   (w_wr_gnt[b])
      );

      // Steer the winning lanes' address and data onto this bank's two ports
      always_comb begin
         w_rd_addr = '0;
         w_wr_addr = '0;
         w_wr_data = '0;
         for (int l = 0; l < NUM_LANES; l++) begin
            if (w_rd_gnt[b][l]) w_rd_addr = w_lane[l].addr;
            if (w_wr_gnt[b][l]) begin
               w_wr_addr = w_lane[l].addr;
               w_wr_data = w_lane[l].wdata;
            end
         end
      end

      // Granted write lands at the accepting edge; held off while in reset
      always_ff @(posedge i_clk) begin
         if (!i_reset && (|w_wr_gnt[b])) begin
            r_mem[w_wr_addr] <= w_wr_data;
         end
      end

      // Sampled at the same edge as the write, so a colliding read sees old contents
      assign w_rd_data[b] = r_mem[w_rd_addr];
   end

   // Per-lane acceptance and read-data return path from the lane's target bank
   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         w_gnt_any[l]    = 1'b0;
         w_lane_rdata[l] = '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            w_gnt_any[l] = w_gnt_any[l] | w_rd_gnt[b][l] | w_wr_gnt[b][l];
            if (32'(w_lane[l].bank) == b) w_lane_rdata[l] = w_rd_data[b];
         end
         o_req_rdy[l] = !i_reset && w_lane[l].vld && (w_oor[l] || w_gnt_any[l]);
         w_rd_acc[l]  = o_req_rdy[l] && !w_lane[l].we;
      end
   end

   // Register one response per accepted read; out-of-range reads return error with zero data
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rsp_vld  <= '0;
         r_rsp_err  <= '0;
         r_rsp_data <= '0;
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            r_rsp_vld[l]  <= w_rd_acc[l];
            r_rsp_err[l]  <= w_rd_acc[l] && w_oor[l];
            r_rsp_data[l] <= (w_rd_acc[l] && !w_oor[l]) ? w_lane_rdata[l] : '0;
         end
      end
   end

   // A response still in flight when reset rises is suppressed for the whole reset
   assign o_rsp_vld  = i_reset ? '0 : r_rsp_vld;
   assign o_rsp_err  = i_reset ? '0 : r_rsp_err;
   assign o_rsp_data = i_reset ? '0 : r_rsp_data;

endmodule
